ha_carry_resolver: RTL

HA_CARRY_RESOLVER -- requirements
Module: ha_carry_resolver

---
 rtl/ha_carry_resolver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ha_carry_resolver.sv
// ha_carry_resolver
//   Resolves a half-adder sum/carry pair into a binary sum. Each clock in BUSY
//   applies one half-adder reduction (s ^= c, c = (s & c) << 1) until the carry
//   vector is zero. The sum is then latched and held until the consumer takes it.
//
// Parameters
//   N          operand width in bits (N >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b present
//   in_ready   block can accept an operand pair (high in IDLE)
//   a, b       N-bit addends, sampled only on the acceptance edge
//   out_valid  result present (high in DONE)
//   out_ready  consumer takes the result
//   result     N+1-bit unsigned sum a+b, changes only when a result is produced
//   iter_cnt   ripple iterations used for the current result
//              (present only when HA_CARRY_RESOLVER_ITER_CNT_EN is defined)
//
// Configuration macro
//   HA_CARRY_RESOLVER_ITER_CNT_EN  adds the iteration counter and iter_cnt port

module ha_carry_resolver #(
    parameter int N = 2,
    localparam int CW = $clog2(N + 2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result
`ifdef HA_CARRY_RESOLVER_ITER_CNT_EN
    ,
    output logic [CW-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [N:0] s;
    logic [N:0] c;
    logic [N:0] sc;

    assign sc = s & c;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = BUSY;
            end
            BUSY: begin
                if (c == '0) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Release goes to IDLE; acceptance is only evaluated in IDLE,
                // so a pair can never be taken on the releasing edge.
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;  // unused encoding recovers in one edge
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: sum/carry reduction and result latch
    // ------------------------------------------------------------------
`ifdef HA_CARRY_RESOLVER_ITER_CNT_EN
    logic [CW-1:0] cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '0;
            c      <= '0;
            result <= '0;
`ifdef HA_CARRY_RESOLVER_ITER_CNT_EN
            cnt      <= '0;
            iter_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s <= {1'b0, a ^ b};
                        c <= {a & b, 1'b0};
`ifdef HA_CARRY_RESOLVER_ITER_CNT_EN
                        cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (c != '0) begin
                        s <= s ^ c;
                        // Bit N of s&c is always zero because a+b fits in
                        // N+1 bits, so dropping it never loses the MSB carry.
                        c <= {sc[N-1:0], 1'b0};
`ifdef HA_CARRY_RESOLVER_ITER_CNT_EN
                        cnt <= cnt + 1'b1;
`endif
                    end else begin
                        result <= s;
`ifdef HA_CARRY_RESOLVER_ITER_CNT_EN
                        iter_cnt <= cnt;
`endif
                    end
                end
                default: ;  // DONE and unused encodings: hold everything
            endcase
        end
    end

endmodule
